// File: rtl/emc_input_filter.sv
// emc_input_filter
// Conditions the 32 registered board-side inputs (alarm, home, limits, general
// IO): optional polarity inversion, a second sync flop, per-channel debounce
// qualified against a microsecond tick, edge capture into sticky event flags
// with an interrupt, and per-axis stop requests for the motion generators.
//
// Channel map: [3:0] alarm, [7:4] home, [15:8] limit (2i+1 = +, 2i = -),
// [31:16] general IO.

module emc_input_filter #(
    parameter int PRESCALE = 10,
    parameter int CNT_W    = 8
) (
    input  logic             clk_10M,
    input  logic             n_rst,
    input  logic [3:0]       F_Alarm,
    input  logic [3:0]       F_Home,
    input  logic [7:0]       F_LimitPN,
    input  logic [15:0]      F_IO_Input,
    input  logic [31:0]      inv_mask,
    input  logic [CNT_W-1:0] filt_us,
    input  logic [31:0]      rise_mask,
    input  logic [31:0]      fall_mask,
    input  logic             evt_en,
    input  logic [31:0]      evt_clr,
    output logic [31:0]      filt_out,
    output logic [31:0]      evt_flag,
    output logic             irq,
    output logic [3:0]       axis_stop_p,
    output logic [3:0]       axis_stop_n
);

    localparam int               NCH        = 32;
    localparam logic [7:0]       PRESC_LAST = 8'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    logic [NCH-1:0]   sync_q_reg;
    logic [7:0]       presc_reg;
    logic             tick;
    logic             bypass;

    logic [CNT_W-1:0] cnt_reg  [NCH];
    logic [CNT_W-1:0] cnt_next [NCH];
    logic [NCH-1:0]   filt_reg;
    logic [NCH-1:0]   filt_next;
    logic [NCH-1:0]   filt_d_reg;

    logic [NCH-1:0]   rise;
    logic [NCH-1:0]   fall;
    logic [NCH-1:0]   evt_reg;
    logic             irq_reg;
    logic [3:0]       stop_p_reg;
    logic [3:0]       stop_n_reg;

    // One-cycle tick on the last count of the free-running prescaler.
    assign tick   = (presc_reg == PRESC_LAST);
    assign bypass = (filt_us == '0);

    // Second sync flop with polarity applied, and the free-running prescaler.
    always_ff @(posedge clk_10M or negedge n_rst) begin
        if (!n_rst) begin
            sync_q_reg <= '0;
            presc_reg  <= '0;
        end else begin
            sync_q_reg <= {F_IO_Input, F_LimitPN, F_Home, F_Alarm} ^ inv_mask;
            presc_reg  <= tick ? 8'd0 : presc_reg + 8'd1;
        end
    end

    // Per-channel qualification. The counter only runs while the synced level
    // disagrees with the filtered level, so any glitch back to the filtered
    // value restarts qualification. The ">=" compare lets a lowered filt_us
    // take effect immediately on a channel that is already mid-count.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            logic mism;
            logic qualified;

            assign mism      = sync_q_reg[gi] ^ filt_reg[gi];
            assign qualified = mism && (cnt_reg[gi] >= filt_us);

            assign filt_next[gi] = (bypass || qualified) ? sync_q_reg[gi] : filt_reg[gi];

            assign cnt_next[gi] = (bypass || !mism || qualified) ? '0 :
                                  (tick && (cnt_reg[gi] != CNT_MAX)) ? cnt_reg[gi] + CNT_W'(1) :
                                  cnt_reg[gi];
        end
    endgenerate

    // Debounce state: counters and filtered levels for all channels.
    always_ff @(posedge clk_10M or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_reg[i] <= '0;
            end
            filt_reg <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                cnt_reg[i] <= cnt_next[i];
            end
            filt_reg <= filt_next;
        end
    end

    assign rise = filt_reg & ~filt_d_reg;
    assign fall = ~filt_reg & filt_d_reg;

    // Edge history, sticky event flags (a new set beats a same-cycle clear),
    // interrupt, and stop requests. Alarm stops an axis in both directions.
    always_ff @(posedge clk_10M or negedge n_rst) begin
        if (!n_rst) begin
            filt_d_reg <= '0;
            evt_reg    <= '0;
            irq_reg    <= 1'b0;
            stop_p_reg <= '0;
            stop_n_reg <= '0;
        end else begin
            filt_d_reg <= filt_reg;
            evt_reg    <= (evt_reg & ~evt_clr) |
                          ({NCH{evt_en}} & ((rise & rise_mask) | (fall & fall_mask)));
            irq_reg    <= |evt_reg;
            for (int i = 0; i < 4; i++) begin
                stop_p_reg[i] <= filt_reg[i] | filt_reg[8 + 2*i + 1];
                stop_n_reg[i] <= filt_reg[i] | filt_reg[8 + 2*i];
            end
        end
    end

    assign filt_out    = filt_reg;
    assign evt_flag    = evt_reg;
    assign irq         = irq_reg;
    assign axis_stop_p = stop_p_reg;
    assign axis_stop_n = stop_n_reg;

endmodule

// File: tb/tb_emc_input_filter.sv
// Self-checking bench for emc_input_filter: directed scenarios for latency,
// glitch rejection, event set/clear priority, stop mapping, inversion and
// reset, plus a randomized bypass run against a stream-level reference model.

module tb_emc_input_filter;

    logic        clk_10M = 1'b0;
    logic        n_rst   = 1'b0;
    logic [3:0]  F_Alarm = '0;
    logic [3:0]  F_Home = '0;
    logic [7:0]  F_LimitPN = '0;
    logic [15:0] F_IO_Input = '0;
    logic [31:0] inv_mask = '0;
    logic [7:0]  filt_us = '0;
    logic [31:0] rise_mask = '0;
    logic [31:0] fall_mask = '0;
    logic        evt_en = 1'b0;
    logic [31:0] evt_clr = '0;
    logic [31:0] filt_out;
    logic [31:0] evt_flag;
    logic        irq;
    logic [3:0]  axis_stop_p;
    logic [3:0]  axis_stop_n;

    int n_vec = 0;
    int n_err = 0;

    emc_input_filter #(.PRESCALE(10), .CNT_W(8)) dut (
        .clk_10M     (clk_10M),
        .n_rst       (n_rst),
        .F_Alarm     (F_Alarm),
        .F_Home      (F_Home),
        .F_LimitPN   (F_LimitPN),
        .F_IO_Input  (F_IO_Input),
        .inv_mask    (inv_mask),
        .filt_us     (filt_us),
        .rise_mask   (rise_mask),
        .fall_mask   (fall_mask),
        .evt_en      (evt_en),
        .evt_clr     (evt_clr),
        .filt_out    (filt_out),
        .evt_flag    (evt_flag),
        .irq         (irq),
        .axis_stop_p (axis_stop_p),
        .axis_stop_n (axis_stop_n)
    );

    // 10 MHz clock
    always #50 clk_10M = ~clk_10M;

    task automatic step();
        @(posedge clk_10M);
        #1;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Return to a quiet state: inputs low, bypass, all flags cleared.
    task automatic settle();
        F_Alarm = '0; F_Home = '0; F_LimitPN = '0; F_IO_Input = '0;
        inv_mask = '0; filt_us = '0; rise_mask = '0; fall_mask = '0;
        evt_en = 1'b0; evt_clr = '1;
        step_n(6);
        evt_clr = '0;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        step_n(3);
        @(negedge clk_10M);
        n_rst = 1'b1;
        step();
        n_vec++; if (filt_out !== 32'h0) begin n_err++; $display("FAIL reset_filt_out got=%h exp=%h", filt_out, 32'h0); end
        n_vec++; if (evt_flag !== 32'h0) begin n_err++; $display("FAIL reset_evt_flag got=%h exp=%h", evt_flag, 32'h0); end
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got=%b exp=0", irq); end
        n_vec++; if (axis_stop_p !== 4'h0) begin n_err++; $display("FAIL reset_stop_p got=%h exp=0", axis_stop_p); end
        n_vec++; if (axis_stop_n !== 4'h0) begin n_err++; $display("FAIL reset_stop_n got=%h exp=0", axis_stop_n); end
    endtask

    // Bypass mode: filt_out is the (inverted) input stream delayed by two
    // clocks; flags/irq/stops are derived from that stream's edges.
    task automatic test_bypass_random();
        logic [31:0] in_v, inv, v_j, v_prev, rm, fm, clr;
        logic [31:0] f_cur, fd_cur, e_cur, e_new;
        logic [3:0]  sp_cur, sn_cur;
        logic        irq_cur, irq_new, en;
        settle();
        in_v = '0; inv = '0; v_prev = '0;
        f_cur = '0; fd_cur = '0; e_cur = '0; irq_cur = 1'b0; sp_cur = '0; sn_cur = '0;
        for (int j = 0; j < 150; j++) begin
            in_v = in_v ^ ($urandom & $urandom & $urandom);
            if (j % 40 == 20) inv = $urandom & $urandom;
            rm  = $urandom;
            fm  = $urandom;
            clr = $urandom & $urandom & $urandom;
            en  = ($urandom_range(0, 3) != 0);
            F_Alarm = in_v[3:0]; F_Home = in_v[7:4];
            F_LimitPN = in_v[15:8]; F_IO_Input = in_v[31:16];
            inv_mask = inv; rise_mask = rm; fall_mask = fm; evt_clr = clr; evt_en = en;
            v_j = in_v ^ inv;
            step();
            e_new   = (e_cur & ~clr) | ({32{en}} & ((f_cur & ~fd_cur & rm) | (~f_cur & fd_cur & fm)));
            irq_new = |e_cur;
            for (int a = 0; a < 4; a++) begin
                sp_cur[a] = f_cur[a] | f_cur[8 + 2*a + 1];
                sn_cur[a] = f_cur[a] | f_cur[8 + 2*a];
            end
            fd_cur  = f_cur;
            f_cur   = v_prev;
            v_prev  = v_j;
            e_cur   = e_new;
            irq_cur = irq_new;
            n_vec++; if (filt_out !== f_cur) begin n_err++; $display("FAIL rand_filt_out j=%0d got=%h exp=%h", j, filt_out, f_cur); end
            n_vec++; if (evt_flag !== e_cur) begin n_err++; $display("FAIL rand_evt_flag j=%0d got=%h exp=%h", j, evt_flag, e_cur); end
            n_vec++; if (irq !== irq_cur) begin n_err++; $display("FAIL rand_irq j=%0d got=%b exp=%b", j, irq, irq_cur); end
            n_vec++; if ({axis_stop_p, axis_stop_n} !== {sp_cur, sn_cur}) begin
                n_err++; $display("FAIL rand_stop j=%0d got=%h/%h exp=%h/%h", j, axis_stop_p, axis_stop_n, sp_cur, sn_cur);
            end
        end
    endtask

    task automatic test_bypass_latency();
        settle();
        evt_en = 1'b1; rise_mask = 32'h0000_0020;
        F_Home = 4'b0010;                 // clock T
        step();
        n_vec++; if (filt_out[5] !== 1'b0) begin n_err++; $display("FAIL byp_t1 got=%b exp=0", filt_out[5]); end
        step();
        n_vec++; if (filt_out[5] !== 1'b1) begin n_err++; $display("FAIL byp_t2 got=%b exp=1", filt_out[5]); end
        n_vec++; if (evt_flag[5] !== 1'b0) begin n_err++; $display("FAIL byp_evt_t2 got=%b exp=0", evt_flag[5]); end
        step();
        n_vec++; if (evt_flag[5] !== 1'b1) begin n_err++; $display("FAIL byp_evt_t3 got=%b exp=1", evt_flag[5]); end
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL byp_irq_t3 got=%b exp=0", irq); end
        step();
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL byp_irq_t4 got=%b exp=1", irq); end
    endtask

    task automatic test_glitch();
        logic saw_high;
        int   k;
        settle();
        filt_us = 8'd5; evt_en = 1'b1; rise_mask = 32'h0001_0000;
        step_n(20);
        saw_high = 1'b0;
        F_IO_Input = 16'h0001;
        for (int i = 0; i < 30; i++) begin step(); saw_high |= filt_out[16]; end
        F_IO_Input = 16'h0000;
        for (int i = 0; i < 60; i++) begin step(); saw_high |= filt_out[16]; end
        n_vec++; if (saw_high !== 1'b0) begin n_err++; $display("FAIL glitch_pass got=%b exp=0", saw_high); end
        n_vec++; if (evt_flag[16] !== 1'b0) begin n_err++; $display("FAIL glitch_evt got=%b exp=0", evt_flag[16]); end
        F_IO_Input = 16'h0001;
        k = 0;
        for (int i = 1; i <= 100; i++) begin
            step();
            if (filt_out[16] === 1'b1) begin k = i; break; end
        end
        n_vec++; if (k < 42 || k > 52) begin n_err++; $display("FAIL glitch_latency got=%0d exp=42..52", k); end
        step();
        n_vec++; if (evt_flag[16] !== 1'b1) begin n_err++; $display("FAIL glitch_evt_after got=%b exp=1", evt_flag[16]); end
    endtask

    task automatic test_clear_race();
        int k;
        settle();
        evt_en = 1'b1; rise_mask = 32'h1;
        F_Alarm = 4'b0001;
        step_n(4);
        n_vec++; if (evt_flag[0] !== 1'b1) begin n_err++; $display("FAIL race_first_set got=%b exp=1", evt_flag[0]); end
        F_Alarm = 4'b0000;
        step_n(3);
        F_Alarm = 4'b0001;
        k = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (filt_out[0] === 1'b1) begin k = i; break; end
        end
        n_vec++; if (k != 2) begin n_err++; $display("FAIL race_rise_wait got=%0d exp=2", k); end
        evt_clr = 32'h1;                  // clear in the same cycle as a rise
        step();
        n_vec++; if (evt_flag[0] !== 1'b1) begin n_err++; $display("FAIL race_set_wins got=%b exp=1", evt_flag[0]); end
        step();                           // clear alone
        evt_clr = 32'h0;
        n_vec++; if (evt_flag[0] !== 1'b0) begin n_err++; $display("FAIL race_clear got=%b exp=0", evt_flag[0]); end
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL race_irq_hold got=%b exp=1", irq); end
        step();
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL race_irq_drop got=%b exp=0", irq); end
    endtask

    task automatic test_stop();
        settle();
        F_LimitPN = 8'b0000_0100;
        step_n(3);
        n_vec++; if (axis_stop_n !== 4'b0010) begin n_err++; $display("FAIL stop_lim_n got=%b exp=0010", axis_stop_n); end
        n_vec++; if (axis_stop_p !== 4'b0000) begin n_err++; $display("FAIL stop_lim_p got=%b exp=0000", axis_stop_p); end
        F_Alarm = 4'b1000;
        step_n(3);
        n_vec++; if (axis_stop_p !== 4'b1000) begin n_err++; $display("FAIL stop_alm_p got=%b exp=1000", axis_stop_p); end
        n_vec++; if (axis_stop_n !== 4'b1010) begin n_err++; $display("FAIL stop_alm_n got=%b exp=1010", axis_stop_n); end
    endtask

    task automatic test_inversion();
        settle();
        evt_en = 1'b1; rise_mask = 32'h8000_0000;
        inv_mask = 32'h8000_0000;
        step();
        n_vec++; if (filt_out[31] !== 1'b0) begin n_err++; $display("FAIL inv_t1 got=%b exp=0", filt_out[31]); end
        step();
        n_vec++; if (filt_out[31] !== 1'b1) begin n_err++; $display("FAIL inv_t2 got=%b exp=1", filt_out[31]); end
        step();
        n_vec++; if (evt_flag[31] !== 1'b1) begin n_err++; $display("FAIL inv_evt got=%b exp=1", evt_flag[31]); end
    endtask

    task automatic test_reset_mid();
        int k;
        settle();
        evt_en = 1'b1; rise_mask = 32'h1;
        F_Alarm = 4'b0001;
        step_n(5);                        // outputs nonzero before reset
        evt_en = 1'b0;
        filt_us = 8'd10;
        F_IO_Input = 16'h0002;
        step_n(50);
        n_rst = 1'b0;
        #5;
        n_vec++; if (filt_out !== 32'h0) begin n_err++; $display("FAIL rstmid_filt_out got=%h exp=0", filt_out); end
        n_vec++; if (evt_flag !== 32'h0) begin n_err++; $display("FAIL rstmid_evt_flag got=%h exp=0", evt_flag); end
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL rstmid_irq got=%b exp=0", irq); end
        n_vec++; if ({axis_stop_p, axis_stop_n} !== 8'h00) begin n_err++; $display("FAIL rstmid_stop got=%h/%h exp=0/0", axis_stop_p, axis_stop_n); end
        @(negedge clk_10M);
        n_rst = 1'b1;
        k = 0;
        for (int i = 1; i <= 150; i++) begin
            step();
            if (filt_out[17] === 1'b1) begin k = i; break; end
        end
        n_vec++; if (k < 91 || k > 101) begin n_err++; $display("FAIL rstmid_latency got=%0d exp=91..101", k); end
    endtask

    initial begin
        test_reset();
        test_bypass_random();
        test_bypass_latency();
        test_glitch();
        test_clear_race();
        test_stop();
        test_inversion();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/emc_input_filter.md
Name: emc_input_filter

Overview:
Consumes the registered board-side inputs (alarm, home, limit±, general IO) produced by the EMC IO register stage. Provides polarity inversion, a second sync flop, per-channel digital debounce, and rising/falling edge detection with sticky event flags and an interrupt line. Also generates registered per-axis stop requests for the motion generators.
All 32 channels are handled as one vector:
- ch[3:0] = alarm
- ch[7:4] = home
- ch[15:8] = limit
- ch[31:16] = IO input

Parameters:
PRESCALE, 10, clk_10M cycles per filter tick (1 µs at 10 MHz); legal range 2..255.
CNT_W, 8, width of the per-channel debounce counter and of filt_us.

Ports:
clk_10M  in  1  system clock
n_rst  in  1  asynchronous active-low reset
F_Alarm  in  4  registered axis alarm inputs
F_Home  in  4  registered home inputs
F_LimitPN  in  8  registered limits; bit 2i+1 = axis i positive, bit 2i = axis i negative
F_IO_Input  in  16  registered general inputs
inv_mask  in  32  1 = invert channel before filtering
filt_us  in  CNT_W  required stable time in ticks; 0 = bypass
rise_mask  in  32  enable rising-edge capture per channel
fall_mask  in  32  enable falling-edge capture per channel
evt_en  in  1  global event capture enable
evt_clr  in  32  write-1-to-clear pulse for evt_flag
filt_out  out  32  debounced channel levels
evt_flag  out  32  sticky edge events
irq  out  1  OR of evt_flag, registered
axis_stop_p  out  4  stop positive motion for axis i
axis_stop_n  out  4  stop negative motion for axis i

Behaviour:
- Reset (async, n_rst low): all of the following clear to 0:
  - outputs filt_out, evt_flag, irq, axis_stop_p, axis_stop_n
  - internal sync_q, prescaler, all debounce counters, filt_d (previous filt_out)
- Sync stage: sync_q <= {F_IO_Input, F_LimitPN, F_Home, F_Alarm} ^ inv_mask, every clock.
- Prescaler:
  - counts 0..PRESCALE-1 and wraps.
  - tick is high for exactly one cycle when the count equals PRESCALE-1.
  - free-running; unaffected by filt_us.
- Debounce, per channel c, when filt_us = 0:
  - filt_out[c] <= sync_q[c] every clock.
  - cnt[c] held at 0.
- Debounce, per channel c, when filt_us ≠ 0:
  - sync_q[c] == filt_out[c]: cnt[c] <= 0. Any glitch restarts qualification.
  - mismatch and cnt[c] >= filt_us: filt_out[c] <= sync_q[c], cnt[c] <= 0.
  - otherwise mismatch and tick: cnt[c] <= cnt[c]+1, saturating at all-ones.
  - ">=" applies so that lowering filt_us mid-count takes effect on the next clock.
- Latency:
  - bypass: input change to filt_out = 2 clocks.
  - filt_us = N: filt_out changes between (N-1)*PRESCALE+2 and N*PRESCALE+2 clocks after the input change, provided the input is stable throughout.
- Edge detect:
  - filt_d <= filt_out every clock.
  - rise = filt_out & ~filt_d; fall = ~filt_out & filt_d.
- Event flags: evt_flag[c] <= (evt_flag[c] & ~evt_clr[c]) | (evt_en & ((rise[c] & rise_mask[c]) | (fall[c] & fall_mask[c]))).
  - Set and clear in the same cycle: set wins.
  - evt_en low blocks new sets only; existing flags hold.
  - Flag is set 1 clock after filt_out changes.
- irq <= |evt_flag, giving 1 clock after the flag.
- Axis stop (registered; 1 clock after filt_out):
  - axis_stop_p[i] <= filt_out[i] | filt_out[8+2i+1]
  - axis_stop_n[i] <= filt_out[i] | filt_out[8+2i]
  - alarm stops both directions.
- Changing inv_mask flips sync_q next clock and is debounced like any real input change, so it can raise an edge event.
- Reset mid-qualification discards the count. After reset release, a channel held high in bypass produces a rise event 3 clocks later if evt_en and rise_mask are set. Software keeps evt_en low until inputs settle.

Test Plan:
1. Bypass: filt_us=0, evt_en=1, rise_mask[5]=1; raise F_Home[1] at clock T -> filt_out[5]=1 at T+2, evt_flag[5]=1 at T+3, irq=1 at T+4.
2. Glitch reject: filt_us=5, PRESCALE=10; 30-cycle pulse on F_IO_Input[0] -> filt_out[16] stays 0, no event. 60-cycle level -> filt_out[16]=1 within 42..52 clocks of the change.
3. Clear race: evt_flag[0]=1 with evt_clr[0]=1 asserted in the same cycle as a new masked rise on ch0 -> evt_flag[0] stays 1. Clear alone -> 0 next clock; irq drops the clock after.
4. Limit/alarm stop: bypass, F_LimitPN=8'b0000_0100 -> axis_stop_n=4'b0010, axis_stop_p=0. Then F_Alarm[3]=1 -> axis_stop_p[3] and axis_stop_n[3] both 1.
5. Inversion: inv_mask[31]=1, F_IO_Input[15]=0, filt_us=0 -> filt_out[31]=1 two clocks after the mask write. A rise event is captured if enabled.
6. Reset mid-count: filt_us=10, input changed, pull n_rst low at 50 cycles -> all outputs 0 immediately. After release with the input still high, qualification restarts from 0 (91..101 clocks measured from the first post-reset clock).
